// File: rtl/conv_output_writer.sv
// Packs one convolution result bit per cycle into DATA_W-bit words and writes
// them to output SRAM, with row-end / frame-end flushes and overflow guarding.
module conv_output_writer #(
    parameter int unsigned          DATA_W    = 16,
    parameter int unsigned          ADDR_W    = 12,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic              res_valid,
    input  logic              res_bit,
    input  logic              row_end,
    input  logic              frame_end,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic              writer_done,
    output logic              writer_busy,
    output logic [ADDR_W-1:0] words_written,
    output logic              addr_overflow
);

    localparam int unsigned IW = $clog2(DATA_W + 1);
    localparam int unsigned PW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pack_q, pack_d;
    logic [IW-1:0]     idx_q, idx_d;
    // One extra MSB marks that the address has run past the top of the SRAM.
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] word;
    logic [IW-1:0]     idx_n;
    logic              req;

    always_comb begin
        state_d   = state_q;
        pack_d    = pack_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        word      = pack_q;
        idx_n     = idx_q;
        req       = 1'b0;

        if (start) begin
            state_d = RUN;
            pack_d  = '0;
            idx_d   = '0;
            addr_d  = {1'b0, BASE_ADDR};
            cnt_d   = '0;
            ovf_d   = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (res_valid) begin
                        word[idx_q[PW-1:0]] = res_bit;
                        idx_n = idx_q + IW'(1);
                    end
                    // A full word and a row end in the same cycle still yield one write.
                    req    = (idx_n == IW'(DATA_W)) || (row_end && (idx_n != '0));
                    pack_d = req ? '0 : word;
                    idx_d  = req ? '0 : idx_n;
                    if (frame_end) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    if (idx_q != '0) begin
                        req    = 1'b1;
                        pack_d = '0;
                        idx_d  = '0;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (req) begin
            if (addr_q[ADDR_W]) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q[ADDR_W-1:0];
                wr_data_d = word;
                addr_d    = addr_q + (ADDR_W + 1)'(1);
                cnt_d     = cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            pack_q    <= '0;
            idx_q     <= '0;
            addr_q    <= {1'b0, BASE_ADDR};
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pack_q    <= pack_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign dut_sram_write_address = wr_addr_q;
    assign dut_sram_write_data    = wr_data_q;
    assign dut_sram_write_enable  = wr_en_q;
    assign writer_done            = done_q;
    assign writer_busy            = busy_q;
    assign words_written          = cnt_q;
    assign addr_overflow          = ovf_q;

endmodule
